// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, MSB-first paced serial bitstream out with per-bit strobe
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             word_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t         state;
  logic [WIDTH-1:0] hold;
  logic [BW-1:0]  bit_cnt;
  logic [DW-1:0]  div_cnt;
  logic           tick, last, hs;
  // outputs decode purely from registered state; in_ready opens only on the final strobe
  assign tick       = state == SHIFT && div_cnt == DW'(DIV - 1);
  assign last       = tick && bit_cnt == BW'(WIDTH - 1);
  assign shift_en   = tick;
  assign word_done  = last;
  assign in_ready   = state == IDLE || last;
  assign busy       = state == SHIFT;
  assign serial_out = state == SHIFT && hold[WIDTH-1];
  assign hs         = in_valid && in_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hold    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (hs) begin
      state   <= SHIFT;
      hold    <= in_data;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (tick) begin
        hold    <= {hold[WIDTH-2:0], 1'b0};
        div_cnt <= '0;
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        state   <= last ? IDLE : SHIFT;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of three serializer configurations with a downstream shift register model
module tb_piso_serializer;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  logic [7:0] da = 0, db = 0, sr = 0, w;
  logic [1:0] dc = 0;
  logic va = 0, vb = 0, vc = 0;
  logic ra, sa, ea, wa, ba, rb, sb, eb, wb, bb, rc, sc, ec, wc, bc;
  int n = 0, nf = 0;

  piso_serializer #(.WIDTH(8), .DIV(1)) ua (.clock(clock), .reset(reset), .in_data(da), .in_valid(va),
    .in_ready(ra), .serial_out(sa), .shift_en(ea), .word_done(wa), .busy(ba));
  piso_serializer #(.WIDTH(8), .DIV(3)) ub (.clock(clock), .reset(reset), .in_data(db), .in_valid(vb),
    .in_ready(rb), .serial_out(sb), .shift_en(eb), .word_done(wb), .busy(bb));
  piso_serializer #(.WIDTH(2), .DIV(1)) uc (.clock(clock), .reset(reset), .in_data(dc), .in_valid(vc),
    .in_ready(rc), .serial_out(sc), .shift_en(ec), .word_done(wc), .busy(bc));

  // downstream shift_register: MSB-first capture on each strobe
  always_ff @(posedge clock) if (ea) sr <= {sr[6:0], sa};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic ser_a(input logic [7:0] word);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("a_bit%0d", k), sa, word[8-k]);
      chk($sformatf("a_se%0d", k), ea, 1);
      chk($sformatf("a_wd%0d", k), wa, k == 8);
      chk($sformatf("a_rdy%0d", k), ra, k == 8);
      step();
    end
    chk("a_pout", sr, word);
    chk("a_idle", ba, 0);
  endtask

  initial begin
    step();
    chk("rst_rdy", {ra, rb, rc}, 3'b111);
    chk("rst_out", {sa, ea, wa, ba, sb, eb, wb, bb, sc, ec, wc, bc}, 0);
    reset = 0;
    step();
    // WIDTH=8 DIV=1, 0xA5
    da = 8'hA5; va = 1;
    chk("a_rdy0", ra, 1);
    step();
    va = 0;
    ser_a(8'hA5);
    // WIDTH=8 DIV=3, 0x81
    db = 8'h81; vb = 1;
    step();
    vb = 0;
    for (int c = 1; c <= 25; c++) begin
      chk($sformatf("b_se%0d", c), eb, c % 3 == 0 && c <= 24);
      chk($sformatf("b_bit%0d", c), sb, c <= 3 || (c >= 22 && c <= 24));
      chk($sformatf("b_wd%0d", c), wb, c == 24);
      chk($sformatf("b_busy%0d", c), bb, c <= 24);
      step();
    end
    // back-to-back 0x3C then 0xC3 with valid held
    da = 8'h3C; va = 1;
    step();
    da = 8'hC3;
    for (int c = 1; c <= 16; c++) begin
      w = c <= 8 ? 8'h3C : 8'hC3;
      if (c == 9) begin
        va = 0;
        chk("bb_pout1", sr, 8'h3C);
      end
      chk($sformatf("bb_bit%0d", c), sa, w[7-((c-1)%8)]);
      chk($sformatf("bb_se%0d", c), ea, 1);
      chk($sformatf("bb_wd%0d", c), wa, c == 8 || c == 16);
      chk($sformatf("bb_rdy%0d", c), ra, c == 8 || c == 16);
      step();
    end
    chk("bb_pout2", sr, 8'hC3);
    chk("bb_idle", ba, 0);
    // 0x00 with 0xFF offered while busy
    da = 8'h00; va = 1;
    step();
    va = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) begin
        va = 1; da = 8'hFF;
      end
      if (c == 6) va = 0;
      chk($sformatf("ig_bit%0d", c), sa, 0);
      chk($sformatf("ig_wd%0d", c), wa, c == 8);
      step();
    end
    chk("ig_idle", {ba, wa}, 0);
    chk("ig_pout", sr, 8'h00);
    step();
    chk("ig_nodup", {ba, wa, ea}, 0);
    // async reset during bit 4 of 0x5A
    da = 8'h5A; va = 1;
    step();
    va = 0;
    repeat (4) step();
    chk("ar_bit4", sa, 1);
    #2 reset = 1;
    #1;
    chk("ar_rdy", ra, 1);
    chk("ar_out", {sa, ea, wa, ba}, 0);
    step();
    chk("ar_hold", {sa, ea, wa, ba}, 0);
    reset = 0;
    step();
    chk("ar_quiet", {sa, ea, wa, ba, ra}, 5'b00001);
    da = 8'h12; va = 1;
    step();
    va = 0;
    ser_a(8'h12);
    // WIDTH=2 boundary
    dc = 2'b10; vc = 1;
    chk("c_rdy0", rc, 1);
    step();
    vc = 0;
    for (int c = 1; c <= 2; c++) begin
      chk($sformatf("c_bit%0d", c), sc, c == 1);
      chk($sformatf("c_se%0d", c), ec, 1);
      chk($sformatf("c_wd%0d", c), wc, c == 2);
      chk($sformatf("c_rdy%0d", c), rc, c == 2);
      step();
    end
    chk("c_idle", {bc, ec, wc}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, nf);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the `shift_register` block. It accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first as `serial_out` with a one-cycle `shift_en` strobe per bit. A paced divider controls the bit rate. When `serial_out`/`shift_en` drive the downstream shift register's `serial_in`/`shift_en` on the same clock, its `parallel_out` equals the loaded word after the final strobe.

## Interface
- WIDTH, 8: word width in bits; legal range ≥ 2.
- DIV, 1: clocks per serial bit; legal range ≥ 1.
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_data  input  WIDTH  word to serialize; sampled only on handshake.
- in_valid  input  1  source has a word.
- in_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  current bit (MSB first); stable for the whole bit period.
- shift_en  output  1  one-cycle strobe; downstream samples `serial_out` on this edge.
- word_done  output  1  one-cycle pulse coincident with the last `shift_en` of a word.
- busy  output  1  high while a word is being shifted.

## Operation
- Internal state:
  - FSM states: IDLE and SHIFT.
  - Holding register `hold[WIDTH-1:0]`.
  - `bit_cnt`, $clog2(WIDTH) bits, counts 0..WIDTH-1.
  - `div_cnt`, $clog2(DIV) bits (minimum 1), counts 0..DIV-1.
- Reset values:
  - State = IDLE; `hold`, `bit_cnt` and `div_cnt` = 0.
  - Outputs: `in_ready`=1, `serial_out`=0, `shift_en`=0, `word_done`=0, `busy`=0.
- Handshake: a word is accepted on a posedge where `in_valid && in_ready`.
  - `in_data` is ignored at all other times.
  - A word is never dropped or duplicated.
- IDLE:
  - `in_ready`=1, `busy`=0, `serial_out`=0.
  - On handshake: load `hold` = `in_data`, clear `bit_cnt` and `div_cnt`, go to SHIFT.
- SHIFT:
  - `busy`=1, `serial_out` = `hold[WIDTH-1]`.
  - `div_cnt` increments each cycle.
  - `shift_en` = (`div_cnt` == DIV-1).
- On a `shift_en` cycle:
  - `hold` shifts left by one, LSB filled with 0.
  - `div_cnt` wraps to 0; `bit_cnt` increments.
- Final strobe (`shift_en` && `bit_cnt` == WIDTH-1):
  - `word_done`=1 and `in_ready`=1 in that same cycle.
  - With handshake: load the new word, clear counters, stay in SHIFT (no bubble).
  - Without handshake: return to IDLE.
- `in_ready` is 0 in every other SHIFT cycle.
- All outputs decode from registered state only; there is no combinational path from `in_valid`/`in_data` to any output.
- Reset mid-word: the current word is discarded and the block returns to reset values. Outputs resume only after a new handshake.

## Timing
- Handshake at cycle N from IDLE:
  - SHIFT from N+1.
  - Bit k (k = 0 is MSB) on `serial_out` during cycles N+1+k·DIV .. N+(k+1)·DIV.
  - `shift_en` at cycle N+(k+1)·DIV.
  - `word_done` at N+WIDTH·DIV.
  - Back in IDLE at N+WIDTH·DIV+1 if no new word was accepted.
- Latency from handshake to first strobe: DIV cycles.
- Sustained throughput with `in_valid` held high: one word per WIDTH·DIV cycles. `shift_en` is strictly periodic with period DIV; for DIV=1 it is high every cycle.
- Downstream `parallel_out` equals the word in the cycle after `word_done`.

## Test plan
- WIDTH=8, DIV=1, load 0xA5 at cycle 0 → `serial_out` = 1,0,1,0,0,1,0,1 in cycles 1–8, `shift_en` high in cycles 1–8, `word_done` in cycle 8, `in_ready` low in cycles 1–7, chained `shift_register` `parallel_out`=0xA5 at cycle 9.
- WIDTH=8, DIV=3, load 0x81 at cycle 0 → `shift_en` only at cycles 3,6,…,24; `serial_out`=1 in cycles 1–3 and 22–24, otherwise 0; `word_done` at 24.
- DIV=1, `in_valid` held high with 0x3C then 0xC3 → 16 consecutive `shift_en` cycles (1–16), handshakes at cycles 0 and 8, `word_done` at 8 and 16, `parallel_out`=0x3C at 9 and 0xC3 at 17.
- `in_valid` pulsed with 0xFF at cycles 3–5 while shifting 0x00 → not accepted; `serial_out` stays 0 for the whole word; no extra `word_done`.
- `reset` asserted asynchronously mid-cycle during bit 4 of 0x5A → all outputs reach reset values before the next posedge; `word_done` never fires; a new word 0x12 after release serializes correctly.
- WIDTH=2, DIV=1 boundary, load 0b10 → `serial_out` 1,0 with `word_done` at cycle 2.
